// File: rtl/dpmem_bist_checker.sv
// Write-then-read BIST engine for a 1W/1R pipelined block-RAM on clk48.
// Optional fault injection on the write port: define DPMEM_BIST_ERROR_INJECT_EN.
module dpmem_bist_checker #(
   parameter int          ADDR_WIDTH   = 14,
   parameter int          DATA_WIDTH   = 32,
   parameter int          READ_LATENCY = 2,
   parameter logic [31:0] SEED         = 32'h1
) (
   input  logic                  clk48,
   input  logic                  rst,
   input  logic                  start,
`ifdef DPMEM_BIST_ERROR_INJECT_EN
   input  logic                  inject_error,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           error_count,
   output logic [ADDR_WIDTH-1:0] first_fail_addr,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [ADDR_WIDTH-1:0] read_address,
   input  logic [DATA_WIDTH-1:0] read_data
);

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   // Counter also times GAP/DRAIN, so keep at least 8 bits for small address widths.
   localparam int              CNT_W    = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
   localparam logic [CNT_W-1:0] CNT_AMAX = CNT_W'({ADDR_WIDTH{1'b1}});
   localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(READ_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_DRN  = CNT_W'(READ_LATENCY);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE} state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'd0);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [31:0]           r_lfsr;
   logic                  w_start_acc, w_wr, w_rd, w_reload, w_finish;
   logic                  w_mismatch;
   logic [15:0]           w_err_nxt;
   logic [DATA_WIDTH-1:0] w_inj_mask;

   // Stage 0 lines up with the registered read_address; stage READ_LATENCY meets read_data.
   logic                  r_vld_p  [0:READ_LATENCY];
   logic [DATA_WIDTH-1:0] r_exp_p  [0:READ_LATENCY];
   logic [ADDR_WIDTH-1:0] r_addr_p [0:READ_LATENCY];

`ifdef DPMEM_BIST_ERROR_INJECT_EN
   assign w_inj_mask = DATA_WIDTH'(inject_error);
`else
   assign w_inj_mask = '0;
`endif

   assign w_mismatch = r_vld_p[READ_LATENCY] && (read_data != r_exp_p[READ_LATENCY]);
   assign w_err_nxt  = w_start_acc ? 16'd0 : (w_mismatch ? sat_inc(error_count) : error_count);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start_acc = 1'b0;
      w_wr        = 1'b0;
      w_rd        = 1'b0;
      w_reload    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_WRITE;
               w_cnt_nxt   = '0;
            end
         end
         S_WRITE: begin
            w_wr      = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_AMAX) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
            end
         end
         S_GAP: begin
            w_reload  = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_GAP) begin
               w_state_nxt = S_READ;
               w_cnt_nxt   = '0;
            end
         end
         S_READ: begin
            w_rd      = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_AMAX) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end
         end
         S_DRAIN: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_DRN) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk48) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_lfsr          <= SEED_EFF;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         error_count     <= '0;
         first_fail_addr <= '0;
         write_enable    <= 1'b0;
         write_address   <= '0;
         write_data      <= '0;
         read_address    <= '0;
         for (int i = 0; i <= READ_LATENCY; i++) r_vld_p[i] <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_start_acc || w_reload)
            r_lfsr <= SEED_EFF;
         else if (w_wr || w_rd)
            r_lfsr <= lfsr_step(r_lfsr);

         write_enable <= w_wr;
         if (w_wr) begin
            write_address <= r_cnt[ADDR_WIDTH-1:0];
            write_data    <= r_lfsr[DATA_WIDTH-1:0] ^ w_inj_mask;
         end
         if (w_rd) read_address <= r_cnt[ADDR_WIDTH-1:0];

         if (w_start_acc) begin
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
         end else if (w_finish) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (w_err_nxt == 16'd0);
         end

         error_count <= w_err_nxt;
         if (w_start_acc)
            first_fail_addr <= '0;
         else if (w_mismatch && error_count == 16'd0)
            first_fail_addr <= r_addr_p[READ_LATENCY];

         r_vld_p[0] <= w_rd;
         for (int i = 1; i <= READ_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
      end
   end

   always_ff @(posedge clk48) begin
      r_exp_p[0]  <= r_lfsr[DATA_WIDTH-1:0];
      r_addr_p[0] <= r_cnt[ADDR_WIDTH-1:0];
      for (int i = 1; i <= READ_LATENCY; i++) begin
         r_exp_p[i]  <= r_exp_p[i-1];
         r_addr_p[i] <= r_addr_p[i-1];
      end
   end

endmodule

// File: tb/tb_dpmem_bist_checker.sv
// Scoreboard bench for dpmem_bist_checker with a 2-cycle read-first memory model.
module tb_dpmem_bist_checker;

   logic        clk48 = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        inject_error = 1'b0;
   logic        busy, done, pass, write_enable;
   logic [15:0] error_count;
   logic [3:0]  first_fail_addr, write_address, read_address;
   logic [31:0] write_data, read_data;

   dpmem_bist_checker #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .SEED(32'h1)
   ) dut (
      .clk48(clk48), .rst(rst), .start(start),
`ifdef DPMEM_BIST_ERROR_INJECT_EN
      .inject_error(inject_error),
`endif
      .busy(busy), .done(done), .pass(pass), .error_count(error_count),
      .first_fail_addr(first_fail_addr), .write_enable(write_enable),
      .write_address(write_address), .write_data(write_data),
      .read_address(read_address), .read_data(read_data)
   );

   always #5 clk48 = ~clk48;

   int cyc = 0;
   always @(posedge clk48) cyc <= cyc + 1;

   // Memory model: faults applied on write (flip mask, then stuck-at-1 mask).
   logic [31:0] mem  [0:15];
   logic [31:0] flip [0:15];
   logic [31:0] s1   [0:15];
   logic [31:0] rd1, rd2;
   always @(posedge clk48) begin
      if (write_enable) mem[write_address] <= (write_data ^ flip[write_address]) | s1[write_address];
      rd1 <= mem[read_address];
      rd2 <= rd1;
   end
   assign read_data = rd2;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   typedef struct { logic [3:0] a; logic [31:0] d; } wexp_t;
   typedef struct { int c; logic p; logic [15:0] ec; logic [3:0] ffa; } rexp_t;
   wexp_t wq[$];
   rexp_t rq[$];

   function automatic logic [31:0] lfsr_nx(input logic [31:0] v);
      logic [31:0] r;
      r = {1'b0, v[31:1]};
      if (v[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   // Push the expected write stream and final result for a run accepted at edge t.
   task automatic launch(input int t, input int inj_addr);
      logic [31:0] l, wd, stored;
      int          errs;
      logic [3:0]  ff;
      bit          got;
      rexp_t       r;
      l = 32'h1; errs = 0; ff = '0; got = 0;
      for (int a = 0; a < 16; a++) begin
         wd = l ^ ((a == inj_addr) ? 32'h1 : 32'h0);
         wq.push_back('{a: 4'(a), d: wd});
         stored = (wd ^ flip[a]) | s1[a];
         if (stored != l) begin
            errs++;
            if (!got) begin ff = 4'(a); got = 1; end
         end
         l = lfsr_nx(l);
      end
      r.c = t + 39; r.p = (errs == 0); r.ec = 16'(errs); r.ffa = ff;
      rq.push_back(r);
   endtask

   logic done_q = 1'b0;
   always @(negedge clk48) begin
      wexp_t w;
      rexp_t r;
      if (write_enable) begin
         if (wq.size() == 0) chk("we_extra", 64'(write_enable), 64'd0);
         else begin
            w = wq.pop_front();
            chk("wr_addr", 64'(write_address), 64'(w.a));
            chk("wr_data", 64'(write_data), 64'(w.d));
         end
      end
      if (done && !done_q) begin
         if (rq.size() == 0) chk("done_extra", 64'(done), 64'd0);
         else begin
            r = rq.pop_front();
            chk("done_cycle", 64'(cyc), 64'(r.c));
            chk("pass", 64'(pass), 64'(r.p));
            chk("err_cnt", 64'(error_count), 64'(r.ec));
            chk("ffa", 64'(first_fail_addr), 64'(r.ffa));
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("wr_left", 64'(wq.size()), 64'd0);
         end
      end
      done_q <= done;
   end

   // Edge numbers are relative to the start-accept edge T; 0 disables an action.
   task automatic run_test(input int restart_e, input int rst_e, input int inj_e);
      int t, k;
      bit fin;
      @(negedge clk48);
      start = 1'b1;
      t = cyc + 1;
      launch(t, (inj_e > 0) ? inj_e - 1 : -1);
      @(negedge clk48);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("done_after_start", 64'(done), 64'd0);
      fin = 0;
      for (int n = 0; n < 200 && !fin; n++) begin
         k = cyc - t;
         start = (restart_e > 0) && (k == restart_e - 1);
         inject_error = (inj_e > 0) && (k == inj_e - 1);
         if ((rst_e > 0) && (k == rst_e - 1)) rst = 1'b1;
         @(negedge clk48);
         if (rst) begin
            chk("rst_we", 64'(write_enable), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            rst = 1'b0;
            wq.delete();
            rq.delete();
            fin = 1;
         end else if (rq.size() == 0) fin = 1;
      end
      start = 1'b0;
      inject_error = 1'b0;
      if (!fin) chk("timeout", 64'd0, 64'd1);
   endtask

   task automatic clear_faults();
      for (int a = 0; a < 16; a++) begin
         flip[a] = '0;
         s1[a]   = '0;
      end
   endtask

   initial begin
      clear_faults();
      for (int a = 0; a < 16; a++) mem[a] = '0;
      rd1 = '0; rd2 = '0;
      repeat (3) @(negedge clk48);
      chk("rst_busy0", 64'(busy), 64'd0);
      chk("rst_done0", 64'(done), 64'd0);
      chk("rst_pass0", 64'(pass), 64'd0);
      chk("rst_err0", 64'(error_count), 64'd0);
      chk("rst_ffa0", 64'(first_fail_addr), 64'd0);
      chk("rst_we0", 64'(write_enable), 64'd0);
      chk("rst_wa0", 64'(write_address), 64'd0);
      chk("rst_wd0", 64'(write_data), 64'd0);
      chk("rst_ra0", 64'(read_address), 64'd0);
      rst = 1'b0;
      @(negedge clk48);

      run_test(0, 0, 0);                       // clean memory
      s1[5] = 32'h8;
      run_test(0, 0, 0);                       // stuck-at-1 bit 3 of address 5
      clear_faults();
      flip[9] = 32'h10;
      flip[2] = 32'h1;
      run_test(0, 0, 0);                       // two corrupted words
      clear_faults();
      run_test(0, 10, 0);                      // reset during WRITE
      run_test(0, 0, 0);
      run_test(20, 0, 0);                      // start while busy is ignored
      run_test(0, 0, 0);                       // restart straight from DONE
`ifdef DPMEM_BIST_ERROR_INJECT_EN
      run_test(0, 0, 8);                       // inject into the write of address 7
`endif
      repeat (2) @(negedge clk48);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
